// File: rtl/udsweep_pkg.sv
// Shared types for the up/down sweep controller: FSM state encoding.
package udsweep_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/udsweep_ctrl_if.sv
// Host-side control/status bundle of the sweep controller.
interface udsweep_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int NSW_W = 8
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [NSW_W-1:0] n_sweeps;
    logic             busy;
    logic             sweep_done;
    logic             done;
    logic             err;

    modport master (
        output start, stop, lo, hi, n_sweeps,
        input  busy, sweep_done, done, err
    );

    modport slave (
        input  start, stop, lo, hi, n_sweeps,
        output busy, sweep_done, done, err
    );
endinterface

// File: rtl/udsweep_ctrl.sv
// Drives an up/down counter so it ping-pongs between latched bounds lo..hi,
// reversing one cycle early because the counter output lags the direction.
module udsweep_ctrl
    import udsweep_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NSW_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    udsweep_ctrl_if.slave    ctl,
    input  logic [WIDTH-1:0] count,
    output logic             load_en,
    output logic [WIDTH-1:0] load,
    output logic             down
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [NSW_W-1:0] ONE_N = NSW_W'(1);

    sweep_state_t     state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [NSW_W-1:0] left_q, left_d;
    logic             sweep_done_q, sweep_done_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             out_of_bounds;

    assign out_of_bounds = (count < lo_q) || (count > hi_q);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        left_d       = left_q;
        sweep_done_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctl.start) begin
                    if (ctl.lo < ctl.hi) begin
                        lo_d    = ctl.lo;
                        hi_d    = ctl.hi;
                        left_d  = ctl.n_sweeps;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: state_d = ctl.stop ? IDLE : UP;
            UP: begin
                if (ctl.stop) begin
                    state_d = IDLE;
                end else if (out_of_bounds) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (count == hi_q - ONE_W) begin
                    state_d = DOWN;
                end
            end
            DOWN: begin
                if (ctl.stop) begin
                    state_d = IDLE;
                end else if (out_of_bounds) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (count == lo_q + ONE_W) begin
                    sweep_done_d = 1'b1;
                    if (left_q == ONE_N) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // left == 0 is continuous mode and must not count down
                        if (left_q != '0) left_d = left_q - ONE_N;
                        state_d = UP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q      <= IDLE;
            lo_q         <= '0;
            hi_q         <= '0;
            left_q       <= '0;
            sweep_done_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            left_q       <= left_d;
            sweep_done_q <= sweep_done_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        load_en        = (state_q == IDLE) || (state_q == LOAD);
        load           = lo_q;
        down           = (state_q == DOWN);
        ctl.busy       = (state_q != IDLE);
        ctl.sweep_done = sweep_done_q;
        ctl.done       = done_q;
        ctl.err        = err_q;
    end

endmodule

// File: tb/tb_udsweep_ctrl.sv
// Closed-loop bench: udsweep_ctrl driving a behavioural up/down counter,
// per-cycle expectations queued at run start and compared by a monitor.
module tb_udsweep_ctrl;

    localparam int WIDTH = 4;
    localparam int NSW_W = 8;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             sweep_done;
        logic             done;
        logic             busy;
        logic             down;
        logic             err;
    } obs_t;

    logic             clk;
    logic             rst;
    logic             cnt_rstn;
    logic [WIDTH-1:0] count;
    logic             load_en;
    logic [WIDTH-1:0] load;
    logic             down;

    int   total;
    int   bad;
    obs_t sb_q[$];

    udsweep_ctrl_if #(.WIDTH(WIDTH), .NSW_W(NSW_W)) bus ();

    udsweep_ctrl #(.WIDTH(WIDTH), .NSW_W(NSW_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctl     (bus),
        .count   (count),
        .load_en (load_en),
        .load    (load),
        .down    (down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter in the loop, with its own active-low reset for fault injection.
    always_ff @(posedge clk or negedge cnt_rstn) begin
        if (!cnt_rstn)    count <= '0;
        else if (load_en) count <= load;
        else if (down)    count <= count - 1'b1;
        else              count <= count + 1'b1;
    end

    // Scoreboard consumer: one queued expectation per cycle while the queue is non-empty.
    always @(negedge clk) begin
        obs_t exp_o;
        obs_t act_o;
        if (sb_q.size() != 0) begin
            exp_o = sb_q.pop_front();
            act_o = '{count: count, sweep_done: bus.sweep_done, done: bus.done,
                      busy: bus.busy, down: down, err: bus.err};
            total++;
            if (act_o !== exp_o) begin
                bad++;
                $display("FAIL sweep_cycle t=%0t: got count=%0d sd=%b done=%b busy=%b down=%b err=%b, want count=%0d sd=%b done=%b busy=%b down=%b err=%b",
                         $time, act_o.count, act_o.sweep_done, act_o.done, act_o.busy, act_o.down, act_o.err,
                         exp_o.count, exp_o.sweep_done, exp_o.done, exp_o.busy, exp_o.down, exp_o.err);
            end
        end
    end

    // Expected triangle: entry j is cycle T+2+j of a run.
    task automatic push_span(input int lo, input int hi, input int n_entries);
        int d;
        int k;
        obs_t e;
        d = hi - lo;
        for (int j = 0; j < n_entries; j++) begin
            k = j % (2 * d);
            e.count      = WIDTH'((k <= d) ? lo + k : lo + 2 * d - k);
            e.sweep_done = (k == 0) && (j > 0);
            e.done       = 1'b0;
            e.busy       = 1'b1;
            e.down       = (k >= d);
            e.err        = 1'b0;
            sb_q.push_back(e);
        end
    endtask

    task automatic push_final(input int lo);
        obs_t e;
        e = '{count: WIDTH'(lo), sweep_done: 1'b1, done: 1'b1, busy: 1'b0, down: 1'b0, err: 1'b0};
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d expectations left, want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Drives start for one cycle, checks the LOAD cycle, returns at edge T+2.
    task automatic start_run(input int lo, input int hi, input int nsw);
        @(negedge clk);
        bus.lo       = WIDTH'(lo);
        bus.hi       = WIDTH'(hi);
        bus.n_sweeps = NSW_W'(nsw);
        bus.start    = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.busy, load_en, down} !== 3'b110) begin
            bad++;
            $display("FAIL load_cycle: busy/load_en/down=%b want 110", {bus.busy, load_en, down});
        end
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        cnt_rstn     = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.lo       = '0;
        bus.hi       = '0;
        bus.n_sweeps = '0;
        repeat (3) @(negedge clk);
        cnt_rstn = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({load_en, load, down, bus.busy, bus.sweep_done, bus.done, bus.err} !== {1'b1, 4'd0, 5'b0}) begin
            bad++;
            $display("FAIL reset_outputs: load_en=%b load=%0d down=%b busy=%b sd=%b done=%b err=%b, want 1 0 0 0 0 0 0",
                     load_en, load, down, bus.busy, bus.sweep_done, bus.done, bus.err);
        end
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("FAIL reset_park: count=%0d want 0", count);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, load_en, count} !== {1'b0, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b load_en=%b count=%0d want 0 1 0", bus.busy, load_en, count);
        end
    endtask

    task automatic test_two_sweeps();
        start_run(3, 6, 2);
        push_span(3, 6, 12);
        push_final(3);
        wait_drain(40);
        @(negedge clk);
        total++;
        if ({count, bus.busy, bus.sweep_done, bus.done} !== {4'd3, 3'b000}) begin
            bad++;
            $display("FAIL park_after_done: count=%0d busy=%b sd=%b done=%b want 3 0 0 0",
                     count, bus.busy, bus.sweep_done, bus.done);
        end
    endtask

    task automatic test_bad_start(input int lo, input int hi);
        @(negedge clk);
        bus.lo       = WIDTH'(lo);
        bus.hi       = WIDTH'(hi);
        bus.n_sweeps = NSW_W'(1);
        bus.start    = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.err, bus.busy, load} !== {1'b1, 1'b0, 4'd3}) begin
            bad++;
            $display("FAIL bad_start_%0d_%0d: err=%b busy=%b load=%0d want 1 0 3", lo, hi, bus.err, bus.busy, load);
        end
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.err, bus.busy, count} !== {1'b0, 1'b0, 4'd3}) begin
            bad++;
            $display("FAIL bad_start_after_%0d_%0d: err=%b busy=%b count=%0d want 0 0 3", lo, hi, bus.err, bus.busy, count);
        end
    endtask

    task automatic test_narrow();
        start_run(4, 5, 3);
        push_span(4, 5, 6);
        push_final(4);
        wait_drain(30);
    endtask

    task automatic test_continuous_stop();
        start_run(0, 15, 0);
        push_span(0, 15, 66);
        wait_drain(100);
        bus.stop = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.busy, load_en, bus.done, bus.sweep_done} !== 4'b0100) begin
            bad++;
            $display("FAIL stop_response: busy=%b load_en=%b done=%b sd=%b want 0 1 0 0",
                     bus.busy, load_en, bus.done, bus.sweep_done);
        end
        bus.stop = 1'b0;
        @(negedge clk);
        total++;
        if ({count, bus.done} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL stop_park: count=%0d done=%b want 0 0", count, bus.done);
        end
    endtask

    task automatic test_bounds_err();
        start_run(2, 9, 0);
        repeat (2) @(negedge clk);
        total++;
        if ({count, bus.busy} !== {4'd3, 1'b1}) begin
            bad++;
            $display("FAIL bounds_pre: count=%0d busy=%b want 3 1", count, bus.busy);
        end
        cnt_rstn = 1'b0;
        @(posedge clk);
        #1 cnt_rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.err, bus.busy, load_en} !== 3'b101) begin
            bad++;
            $display("FAIL bounds_err: err=%b busy=%b load_en=%b want 1 0 1", bus.err, bus.busy, load_en);
        end
        @(negedge clk);
        total++;
        if ({bus.err, count} !== {1'b0, 4'd2}) begin
            bad++;
            $display("FAIL bounds_recover: err=%b count=%0d want 0 2", bus.err, count);
        end
    endtask

    task automatic test_rst_midrun();
        start_run(3, 6, 2);
        push_span(3, 6, 7);
        wait_drain(20);
        rst = 1'b1;
        #1;
        total++;
        if ({load_en, load, down, bus.busy, bus.sweep_done, bus.done, bus.err} !== {1'b1, 4'd0, 5'b0}) begin
            bad++;
            $display("FAIL rst_midrun: load_en=%b load=%0d down=%b busy=%b sd=%b done=%b err=%b, want 1 0 0 0 0 0 0",
                     load_en, load, down, bus.busy, bus.sweep_done, bus.done, bus.err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({count, bus.busy} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL rst_midrun_park: count=%0d busy=%b want 0 0", count, bus.busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_two_sweeps();
        test_bad_start(7, 7);
        test_bad_start(9, 2);
        test_narrow();
        test_continuous_stop();
        test_bounds_err();
        test_rst_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udsweep_ctrl.md
# udsweep_ctrl

Sweep controller that drives the load/direction inputs of the shared up/down counter (`udcount`). It makes the counter ping-pong between programmable bounds `lo` and `hi` for a programmed number of sweeps, or continuously. It sits directly upstream of the counter and reads the counter's `count` back to decide when to reverse. Between runs it parks the counter at `lo`.

## Interface
- `WIDTH`, default 4: counter width; must match the counter instance.
- `NSW_W`, default 8: width of the sweep-count register.

Ports:
- `clk`  in  1: clock; all state on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: level, sampled in IDLE only; latches `lo`, `hi`, `n_sweeps` and begins a run.
- `stop`  in  1: aborts a run; ignored in IDLE.
- `lo`  in  WIDTH: lower bound, unsigned.
- `hi`  in  WIDTH: upper bound, unsigned.
- `n_sweeps`  in  NSW_W: number of sweeps; 0 means continuous until `stop`.
- `count`  in  WIDTH: current counter value, fed back from the counter.
- `load_en`  out  1: counter load enable.
- `load`  out  WIDTH: counter load value.
- `down`  out  1: counter direction; 1 = decrement.
- `busy`  out  1: high whenever the state is not IDLE.
- `sweep_done`  out  1: one-cycle pulse when a lo→hi→lo sweep completes.
- `done`  out  1: one-cycle pulse when the programmed run completes normally.
- `err`  out  1: one-cycle pulse on a bad start or an out-of-bounds `count`.

## Operation
- State register with four states: IDLE, LOAD, UP, DOWN.
- Output decode from the state register (combinational):
  - `load_en` = IDLE or LOAD.
  - `load` = `lo_q`.
  - `down` = DOWN.
  - `busy` = state != IDLE.
- Pulse outputs `sweep_done`, `done` and `err` are registered.
- Reset values:
  - Registers: state=IDLE, `lo_q`=0, `hi_q`=0, `left`=0, all pulses 0.
  - Resulting outputs: `load_en`=1, `load`=0, `down`=0, `busy`=0.
- IDLE, `start`=1 with `lo`<`hi`:
  - Latch `lo_q`, `hi_q`; `left` <= `n_sweeps`.
  - Go to LOAD.
- IDLE, `start`=1 with `lo`>=`hi`: pulse `err`, stay in IDLE, keep the old latched values.
- LOAD → UP unconditionally. `stop` in LOAD goes to IDLE instead.
- UP: when `count`==`hi_q`-1 → DOWN. The counter therefore reaches `hi_q` with `down` already 1.
- DOWN: when `count`==`lo_q`+1, the sweep ends:
  - Pulse `sweep_done`.
  - If `left`==1, pulse `done` and go to IDLE.
  - Otherwise decrement `left` (unless it is 0, continuous mode) and go to UP.
- IDLE holds `load_en`=1, so the counter stays parked at `lo_q`.
- Priority within UP/DOWN, highest first:
  1. `stop`: go to IDLE; no `done`, no `sweep_done`.
  2. Bounds error: `count` < `lo_q` or > `hi_q` → pulse `err`, go to IDLE.
  3. Normal transitions above.
- `start` outside IDLE is ignored.
- `lo`, `hi`, `n_sweeps` are don't-care except in the cycle that `start` is accepted.
- Arithmetic and comparisons are unsigned WIDTH-bit. `hi_q`-1 and `lo_q`+1 never wrap, because `lo_q`<`hi_q` is guaranteed.
- `hi`=`lo`+1 is legal: the counter alternates lo, hi, lo, … and each sweep takes 2 cycles.
- Full range (`lo`=0, `hi`=2^WIDTH-1) is legal; the counter never wraps.
- `rst` asserted mid-run: immediately IDLE with reset values; no pulses.

## Timing
- `start` sampled at edge T. Cycle T+1 is LOAD. `count`=`lo` first appears in cycle T+2.
- In cycle T+2+k, `count` = `lo`+k for k ≤ (`hi`-`lo`).
- A sweep lasts 2·(`hi`-`lo`) cycles.
- `sweep_done` is high in the cycle `count` returns to `lo`.
- On the final sweep, `done` and `sweep_done` are high in the same cycle that `busy` first reads 0.
- `stop` sampled at edge E: `busy`=0 and `load_en`=1 in cycle E+1. The counter shows `lo_q` in cycle E+2.
- `err` from `start`: high in the cycle after `start` is sampled.
- Bounds `err`: high in the cycle after the bad `count` is seen.

## Structure
- Package `udsweep_pkg`: state enum typedef `sweep_state_t` (IDLE, LOAD, UP, DOWN) and its encoding width.
- No sub-module needed.
- One sequential process for state, latched values and pulses; one combinational process for output decode.
- The top-level pairing of `udsweep_ctrl` with `udcount` is the integration test harness, not part of this block.

## Test plan
All scenarios use WIDTH=4 with a real counter instance in the loop.
- Reset with `rst`=1 → `load_en`=1, `load`=0, `down`=0, `busy`=0, no pulses; the counter parks at 0.
- `lo`=3, `hi`=6, `n_sweeps`=2, `start` pulse:
  - `count` from T+2 is 3,4,5,6,5,4,3,4,5,6,5,4,3.
  - `sweep_done` pulses at both returns to 3.
  - `done` coincides with the second `sweep_done`; `busy` is 0 in that cycle.
- `lo`=7, `hi`=7 `start` → `err` pulse, `busy` stays 0. Repeat with `lo`=9, `hi`=2 → same result.
- `n_sweeps`=0, `lo`=0, `hi`=15:
  - Continuous 0..15..0 with no wrap; `sweep_done` every 30 cycles.
  - `stop` mid-sweep → `busy`=0 next cycle, no `done`, `count`=0 two cycles later.
- `lo`=4, `hi`=5, `n_sweeps`=3 → `count` alternates 4,5,4,5,4,5,4; 3 `sweep_done` pulses, then `done`.
- During UP, force the counter via its own `rstn` so `count`=0 with `lo`=2 → `err` pulse, state goes to IDLE. Separately, assert `rst` mid-run → every output returns to its reset value immediately.
